// File: rtl/mem_rd_burst_fsm.sv
// Memory read burst sequencer.
// On go, captures a base address and beat count, then issues read beats,
// stretching each beat while ws is high. Too many consecutive wait states on
// one beat abort the burst with a one-cycle err pulse. A completed burst
// gives a one-cycle ds pulse.
module mem_rd_burst_fsm #(
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned LEN_W    = 4,
   parameter int unsigned WAIT_W   = 4,
   parameter int unsigned MAX_WAIT = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   input  logic              ws,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  burst_len,
   output logic              rd,
   output logic [ADDR_W-1:0] addr,
   output logic              beat_ok,
   output logic              ds,
   output logic              err,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_READ = 2'd1,
      S_DONE = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LEN_W-1:0]    rem_q, rem_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;

   // One extra bit so the compare against MAX_WAIT never sees a wrapped count.
   logic [WAIT_W:0]     wcnt_inc;
   logic                timeout_hit;

   assign wcnt_inc    = {1'b0, wcnt_q} + (WAIT_W+1)'(1);
   assign timeout_hit = (MAX_WAIT != 0) && (wcnt_inc == (WAIT_W+1)'(MAX_WAIT));

   // Next-state and datapath update for the burst sequencer.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      wcnt_d  = wcnt_q;
      case (state_q)
         S_IDLE: begin
            if (go) begin
               state_d = S_READ;
               addr_d  = base_addr;
               rem_d   = burst_len;
               wcnt_d  = '0;
            end
         end
         S_READ: begin
            if (ws) begin
               wcnt_d = wcnt_inc[WAIT_W-1:0];
               if (timeout_hit) begin
                  state_d = S_ERR;
               end
            end else begin
               wcnt_d = '0;
               if (rem_q == '0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d = addr_q + ADDR_W'(1);
                  rem_d  = rem_q - LEN_W'(1);
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         rem_q   <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         wcnt_q  <= wcnt_d;
      end
   end

   // Status outputs decoded from the state register; beat_ok also follows ws.
   always_comb begin
      rd      = (state_q == S_READ);
      ds      = (state_q == S_DONE);
      err     = (state_q == S_ERR);
      busy    = (state_q != S_IDLE);
      beat_ok = (state_q == S_READ) && !ws;
      addr    = addr_q;
   end

endmodule
